switch_ingress_fifo: RTL and testbench



---
 rtl/switch_ingress_fifo.sv | 124 ++++++++++++
 tb/tb_switch_ingress_fifo.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/switch_ingress_fifo.sv
// rtl/switch_ingress_fifo.sv - ingress FIFO feeding the address switch with single-cycle beats
//
// Purpose:
//   Buffers producer transactions (valid/ready) in a circular FIFO and drains
//   them as one-cycle vld/addr/data beats. The switch cannot stall, so a beat
//   is issued on every clock with a queued entry unless pause is high.
//
// Ports:
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   in_vld, in_rdy     producer handshake; a push happens when both are high
//   in_addr, in_data   producer transaction fields
//   pause              holds the queue; no beats issued while high
//   vld, addr, data    registered beat to the switch
//   level, full, empty occupancy status
//   cnt_clr            (SW_INGRESS_CNT_EN only) synchronous clear of the counters
//   cnt_a, cnt_b       (SW_INGRESS_CNT_EN only) beats with addr <= ADDR_DIV / above it
//
// Optional feature macro: SW_INGRESS_CNT_EN

module switch_ingress_fifo #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    DEPTH      = 8,
    parameter logic [ADDR_WIDTH-1:0] ADDR_DIV   = 8'h3F
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      in_vld,
    output logic                      in_rdy,
    input  logic [ADDR_WIDTH-1:0]     in_addr,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic                      pause,
    output logic                      vld,
    output logic [ADDR_WIDTH-1:0]     addr,
    output logic [DATA_WIDTH-1:0]     data,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      full,
    output logic                      empty
`ifdef SW_INGRESS_CNT_EN
    ,
    input  logic                      cnt_clr,
    output logic [15:0]               cnt_a,
    output logic [15:0]               cnt_b
`endif
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [EW-1:0]         mem [DEPTH];
    logic [EW-1:0]         head;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  push;
    logic                  pop;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                    (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign level  = wr_ptr - rd_ptr;
    // Ready depends only on occupancy: a pop in the same cycle does not free a slot.
    assign in_rdy = !full;

    assign push = in_vld && in_rdy;
    assign pop  = !empty && !pause;

    assign head      = mem[rd_ptr[PW-2:0]];
    assign head_addr = head[EW-1 -: ADDR_WIDTH];
    assign head_data = head[DATA_WIDTH-1:0];

    // Storage has no reset; stale contents are never read because the
    // pointers are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PW-2:0]] <= {in_addr, in_data};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            vld    <= 1'b0;
            addr   <= '0;
            data   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                vld    <= 1'b1;
                addr   <= head_addr;
                data   <= head_data;
            end else begin
                vld    <= 1'b0;
            end
        end
    end

`ifdef SW_INGRESS_CNT_EN
    // Classifies each beat by the routing split; a clear on the same edge
    // as a pop discards that pop's count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else if (cnt_clr) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else if (pop) begin
            if (head_addr <= ADDR_DIV) begin
                cnt_a <= cnt_a + 16'd1;
            end else begin
                cnt_b <= cnt_b + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_switch_ingress_fifo.sv
// tb/tb_switch_ingress_fifo.sv - self-checking bench for switch_ingress_fifo

module tb_switch_ingress_fifo;

    logic        clk;
    logic        rstn;
    logic        in_vld;
    logic        in_rdy;
    logic [7:0]  in_addr;
    logic [15:0] in_data;
    logic        pause;
    logic        vld;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [3:0]  level;
    logic        full;
    logic        empty;
`ifdef SW_INGRESS_CNT_EN
    logic        cnt_clr;
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;
`endif

    int tests_run = 0;
    int failures  = 0;

    logic [23:0] sb [$];
    logic        exp_vld;
    logic [23:0] exp_beat;
    logic [3:0]  exp_level;

    switch_ingress_fifo dut (
        .clk     (clk),
        .rstn    (rstn),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .in_addr (in_addr),
        .in_data (in_data),
        .pause   (pause),
        .vld     (vld),
        .addr    (addr),
        .data    (data),
        .level   (level),
        .full    (full),
        .empty   (empty)
`ifdef SW_INGRESS_CNT_EN
        ,
        .cnt_clr (cnt_clr),
        .cnt_a   (cnt_a),
        .cnt_b   (cnt_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: drive inputs, let the model decide push/pop from its own
    // occupancy, then return 1 time unit after the edge for sampling.
    task automatic cycle(input logic v, input logic [7:0] a, input logic [15:0] d,
                         input logic p);
        logic push_m;
        logic pop_m;
        in_vld  = v;
        in_addr = a;
        in_data = d;
        pause   = p;
        push_m  = v && (sb.size() < 8);
        pop_m   = (sb.size() > 0) && !p;
        @(posedge clk);
        exp_vld = pop_m;
        if (pop_m) exp_beat = sb.pop_front();
        if (push_m) sb.push_back({a, d});
        exp_level = 4'(sb.size());
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; in_vld = 1'b0; in_addr = '0; in_data = '0; pause = 1'b0;
`ifdef SW_INGRESS_CNT_EN
        cnt_clr = 1'b0;
`endif
        #1;
        tests_run++; if (vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", vld); end
        tests_run++; if ({addr, data} !== 24'h0) begin failures++; $display("FAIL reset_addr_data got=%h exp=000000", {addr, data}); end
        tests_run++; if (level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        tests_run++; if ({empty, full, in_rdy} !== 3'b101) begin failures++; $display("FAIL reset_flags got=%b exp=101 (empty,full,in_rdy)", {empty, full, in_rdy}); end
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        sb.delete();
    endtask

    task automatic test_single();
        cycle(1'b1, 8'h10, 16'hA5A5, 1'b0);
        tests_run++; if (vld !== 1'b0) begin failures++; $display("FAIL single_no_bypass vld got=%b exp=0", vld); end
        tests_run++; if (level !== 4'd1) begin failures++; $display("FAIL single_level1 got=%0d exp=1", level); end
        cycle(1'b0, 8'h00, 16'h0000, 1'b0);
        tests_run++; if (vld !== 1'b1) begin failures++; $display("FAIL single_vld got=%b exp=1", vld); end
        tests_run++; if ({addr, data} !== 24'h10A5A5) begin failures++; $display("FAIL single_beat got=%h exp=10a5a5", {addr, data}); end
        tests_run++; if ({addr, data} !== exp_beat) begin failures++; $display("FAIL single_sb got=%h exp=%h", {addr, data}, exp_beat); end
        tests_run++; if (level !== 4'd0) begin failures++; $display("FAIL single_level0 got=%0d exp=0", level); end
        cycle(1'b0, 8'h00, 16'h0000, 1'b0);
        tests_run++; if (vld !== 1'b0) begin failures++; $display("FAIL single_one_cycle vld got=%b exp=0", vld); end
    endtask

    task automatic fill_paused(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, base + 8'(i), 16'($urandom), 1'b1);
            tests_run++; if (vld !== 1'b0 || level !== exp_level) begin failures++; $display("FAIL fill_%0d got vld=%b level=%0d exp vld=0 level=%0d", i, vld, level, exp_level); end
        end
    endtask

    task automatic drain(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 8'h00, 16'h0000, 1'b0);
            tests_run++; if (vld !== exp_vld) begin failures++; $display("FAIL %s_vld_%0d got=%b exp=%b", name, i, vld, exp_vld); end
            if (exp_vld) begin
                tests_run++; if ({addr, data} !== exp_beat) begin failures++; $display("FAIL %s_beat_%0d got=%h exp=%h", name, i, {addr, data}, exp_beat); end
            end
            tests_run++; if (level !== exp_level) begin failures++; $display("FAIL %s_level_%0d got=%0d exp=%0d", name, i, level, exp_level); end
        end
    endtask

    task automatic test_fill_pause();
        fill_paused(8, 8'h20);
        tests_run++; if ({full, in_rdy, level} !== {1'b1, 1'b0, 4'd8}) begin failures++; $display("FAIL full_status got full=%b in_rdy=%b level=%0d exp 1 0 8", full, in_rdy, level); end
        cycle(1'b1, 8'hEE, 16'hDEAD, 1'b1);
        tests_run++; if (level !== 4'd8 || vld !== 1'b0) begin failures++; $display("FAIL ninth_push got level=%0d vld=%b exp 8 0", level, vld); end
        drain(8, "paused_drain");
        tests_run++; if (empty !== 1'b1) begin failures++; $display("FAIL paused_drain_empty got=%b exp=1", empty); end
        drain(1, "paused_idle");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 50; i++) begin
            cycle(1'b1, 8'($urandom), 16'($urandom), 1'b0);
            tests_run++; if (vld !== (i > 0)) begin failures++; $display("FAIL b2b_vld_%0d got=%b exp=%b", i, vld, (i > 0)); end
            if (exp_vld) begin
                tests_run++; if ({addr, data} !== exp_beat) begin failures++; $display("FAIL b2b_beat_%0d got=%h exp=%h", i, {addr, data}, exp_beat); end
            end
            tests_run++; if (level > 4'd1 || level !== exp_level) begin failures++; $display("FAIL b2b_level_%0d got=%0d exp=%0d", i, level, exp_level); end
        end
        drain(2, "b2b_tail");
    endtask

    task automatic test_full_pop();
        fill_paused(8, 8'h50);
        cycle(1'b1, 8'h77, 16'h7777, 1'b0);
        tests_run++; if (level !== 4'd7) begin failures++; $display("FAIL fullpop_level got=%0d exp=7", level); end
        tests_run++; if (vld !== 1'b1 || {addr, data} !== exp_beat) begin failures++; $display("FAIL fullpop_beat got vld=%b %h exp 1 %h", vld, {addr, data}, exp_beat); end
        cycle(1'b1, 8'h77, 16'h7777, 1'b1);
        tests_run++; if (level !== 4'd8 || full !== 1'b1) begin failures++; $display("FAIL fullpop_retry got level=%0d full=%b exp 8 1", level, full); end
        drain(9, "fullpop_drain");
        tests_run++; if (sb.size() != 0 || empty !== 1'b1) begin failures++; $display("FAIL fullpop_left got empty=%b sb=%0d exp empty=1 sb=0", empty, sb.size()); end
    endtask

    task automatic test_reset_mid();
        fill_paused(5, 8'h90);
        drain(2, "mid_pre");
        tests_run++; if (vld !== 1'b1) begin failures++; $display("FAIL mid_active got vld=%b exp=1", vld); end
        rstn = 1'b0;
        #1;
        tests_run++; if (vld !== 1'b0 || level !== 4'd0 || empty !== 1'b1) begin failures++; $display("FAIL mid_reset got vld=%b level=%0d empty=%b exp 0 0 1", vld, level, empty); end
        sb.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 8'h00, 16'h0000, 1'b0);
            tests_run++; if (vld !== 1'b0 || level !== 4'd0) begin failures++; $display("FAIL mid_stale_%0d got vld=%b level=%0d exp 0 0", i, vld, level); end
        end
    endtask

`ifdef SW_INGRESS_CNT_EN
    task automatic test_counters();
        cycle(1'b1, 8'h3F, 16'h0001, 1'b1);
        cycle(1'b1, 8'h40, 16'h0002, 1'b1);
        cycle(1'b1, 8'h00, 16'h0003, 1'b1);
        drain(4, "cnt_drain");
        tests_run++; if (cnt_a !== 16'd2 || cnt_b !== 16'd1) begin failures++; $display("FAIL cnt_values got a=%0d b=%0d exp 2 1", cnt_a, cnt_b); end
        cnt_clr = 1'b1;
        cycle(1'b1, 8'h41, 16'h0004, 1'b0);
        cnt_clr = 1'b0;
        tests_run++; if (cnt_a !== 16'd0 || cnt_b !== 16'd0) begin failures++; $display("FAIL cnt_clr got a=%0d b=%0d exp 0 0", cnt_a, cnt_b); end
        cnt_clr = 1'b1;
        cycle(1'b0, 8'h00, 16'h0000, 1'b0);
        cnt_clr = 1'b0;
        tests_run++; if (vld !== 1'b1 || cnt_b !== 16'd0) begin failures++; $display("FAIL cnt_clr_wins got vld=%b b=%0d exp 1 0", vld, cnt_b); end
        drain(1, "cnt_tail");
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill_pause();
        test_back_to_back();
        test_full_pop();
        test_reset_mid();
`ifdef SW_INGRESS_CNT_EN
        test_counters();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
